// File: rtl/conv_window_3x3.sv
`default_nettype none
// ============================================================================
// Module      : conv_window_3x3
// Description : Sliding 3x3 window generator. Consumes a padded row-major
//               pixel stream and emits one 3x3 window (all channels packed
//               side by side) per interior position, (SIZE-2)^2 per frame.
// Revision    : 1.0 - initial release
// ============================================================================
module conv_window_3x3 #(
    parameter int N       = 8,
    parameter int CHANNEL = 3,
    parameter int SIZE    = 34
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     ce,
    input  logic                     din_vld,
    input  logic [CHANNEL*N-1:0]     din,
    output logic [9*CHANNEL*N-1:0]   win_dout,
    output logic                     win_vld,
    output logic                     win_end
);

    localparam int PW = CHANNEL * N;
    localparam int CW = $clog2(SIZE);
    localparam logic [CW-1:0] LAST = CW'(SIZE - 1);
    localparam logic [CW-1:0] TWO  = CW'(2);

    // Position counters, window registers and output strobes
    logic [CW-1:0] col_q, col_d;
    logic [CW-1:0] row_q, row_d;
    logic [PW-1:0] win_q [0:8];
    logic [PW-1:0] win_d [0:8];
    logic          vld_q, vld_d;
    logic          end_q, end_d;

    // Line buffers: lb0 holds row-2, lb1 holds row-1 at each column.
    // Never read before being rewritten within a frame, so left unreset.
    logic [PW-1:0] lb0_mem [0:SIZE-1];
    logic [PW-1:0] lb1_mem [0:SIZE-1];

    logic          w_accept;
    logic [PW-1:0] w_tap [0:2];

    assign w_accept = ce & din_vld;
    assign w_tap[0] = lb0_mem[col_q];
    assign w_tap[1] = lb1_mem[col_q];
    assign w_tap[2] = din;

    // Next-state: counter advance, window shift and strobe generation
    always_comb begin
        col_d = col_q;
        row_d = row_q;
        vld_d = 1'b0;
        end_d = 1'b0;
        for (int k = 0; k < 9; k++) begin
            win_d[k] = win_q[k];
        end

        if (!ce) begin
            // Synchronous clear: restart the frame, window contents hold
            col_d = '0;
            row_d = '0;
        end else if (w_accept) begin
            vld_d = (row_q >= TWO) && (col_q >= TWO);
            end_d = (row_q == LAST) && (col_q == LAST);

            if (col_q == LAST) begin
                col_d = '0;
                row_d = (row_q == LAST) ? '0 : row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end

            // Each window row shifts left; the newest column enters on the right
            for (int r = 0; r < 3; r++) begin
                win_d[3*r]     = win_q[3*r + 1];
                win_d[3*r + 1] = win_q[3*r + 2];
                win_d[3*r + 2] = w_tap[r];
            end
        end
    end

    // State registers with asynchronous reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q <= '0;
            row_q <= '0;
            vld_q <= 1'b0;
            end_q <= 1'b0;
            for (int k = 0; k < 9; k++) begin
                win_q[k] <= '0;
            end
        end else begin
            col_q <= col_d;
            row_q <= row_d;
            vld_q <= vld_d;
            end_q <= end_d;
            for (int k = 0; k < 9; k++) begin
                win_q[k] <= win_d[k];
            end
        end
    end

    // Line buffer update: row-1 moves down to row-2, new pixel becomes row-1
    always_ff @(posedge clk) begin
        if (w_accept) begin
            lb0_mem[col_q] <= lb1_mem[col_q];
            lb1_mem[col_q] <= din;
        end
    end

    // Window registers map straight onto the output taps, k = 3*row + col
    generate
        for (genvar k = 0; k < 9; k++) begin : g_taps
            assign win_dout[k*PW +: PW] = win_q[k];
        end
    endgenerate

    assign win_vld = vld_q;
    assign win_end = end_q;

endmodule
`default_nettype wire
